// File: rtl/bounce_pkg.sv
// Shared types, constants and helpers for the switch bounce generator.
package bounce_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    BOUNCE = 1'b1
  } state_t;

  // Galois feedback mask for x^16+x^14+x^13+x^11+1.
  localparam logic [15:0] LFSR_MASK    = 16'hB400;
  // A zero seed would lock the LFSR, so it is swapped for this value.
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Convert a duration in microseconds to clock cycles at clk_freq Hz.
  function automatic int us_to_cycles(input int clk_freq, input int us);
    return (clk_freq / 1_000_000) * us;
  endfunction

endpackage

// File: rtl/switch_bounce_gen_if.sv
// Control/observation bundle for the switch bounce generator.
interface switch_bounce_gen_if;
  logic start;
  logic target;
  logic sw;
  logic busy;
  logic done;

  // Side that requests sequences and watches the emulated switch.
  modport master (output start, output target, input sw, input busy, input done);
  // Side that emulates the switch.
  modport slave  (input start, input target, output sw, output busy, output done);
endinterface

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR that steps only when asked, reset to a non-zero seed.
module lfsr16
  import bounce_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] seed_i,
  input  logic        adv_i,
  output logic [15:0] value_o
);

  logic [15:0] value_q;
  logic [15:0] value_d;
  logic [15:0] seed_eff;

  assign seed_eff = (seed_i == 16'd0) ? DEFAULT_SEED : seed_i;

  // Next LFSR value: shift right, fold the feedback mask in when bit 0 falls out.
  always_comb begin
    value_d = value_q;
    if (adv_i) begin
      value_d = value_q[0] ? ((value_q >> 1) ^ LFSR_MASK) : (value_q >> 1);
    end
  end

  // LFSR register; reset reloads the (sanitised) seed.
  always_ff @(posedge clk_i) begin
    if (rst_i) value_q <= seed_eff;
    else       value_q <= value_d;
  end

  assign value_o = value_q;

endmodule

// File: rtl/switch_bounce_gen.sv
// Emulates a bouncing mechanical switch: random toggles for a fixed window,
// then settles at the requested level and pulses done_o.
module switch_bounce_gen
  import bounce_pkg::*;
#(
  parameter int          ClkFreq      = 100_000_000,
  parameter int          BounceTimeUs = 2000,
  parameter int          MinSegCycles = 16,
  parameter int          SegBits      = 8,
  parameter logic [15:0] LfsrSeed     = 16'hACE1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic target_i,
  output logic sw_o,
  output logic busy_o,
  output logic done_o
);

  localparam int BounceCycles = us_to_cycles(ClkFreq, BounceTimeUs);
  localparam int BcntW        = $clog2(BounceCycles);
  localparam int SegWRaw      = $clog2(MinSegCycles + (1 << SegBits));
  localparam int SegW         = (SegWRaw < 1) ? 1 : SegWRaw;
  localparam logic [15:0] SegMask = 16'((32'd1 << SegBits) - 32'd1);

  state_t           state_q, state_d;
  logic [BcntW-1:0] bcnt_q, bcnt_d;
  logic [SegW-1:0]  seg_q, seg_d;
  logic             sw_q, sw_d;
  logic             target_q, target_d;
  logic             done_q, done_d;
  logic             lfsr_adv;
  logic [15:0]      lfsr_value;
  logic [SegW-1:0]  seg_load;

  lfsr16 u_lfsr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .seed_i  (LfsrSeed),
    .adv_i   (lfsr_adv),
    .value_o (lfsr_value)
  );

  // Length of the next stable interval, minus one (seg counts down to 0).
  assign seg_load = SegW'(32'(MinSegCycles - 1) + {16'd0, lfsr_value & SegMask});

  // Next-state logic: accept in IDLE, count the window and segments in BOUNCE.
  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    seg_d    = seg_q;
    sw_d     = sw_q;
    target_d = target_q;
    done_d   = 1'b0;
    lfsr_adv = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          target_d = target_i;
          bcnt_d   = BcntW'(BounceCycles - 1);
          seg_d    = seg_load;
          lfsr_adv = 1'b1;
          sw_d     = ~sw_q;
          state_d  = BOUNCE;
        end
      end
      BOUNCE: begin
        if (bcnt_q != '0) begin
          bcnt_d = bcnt_q - BcntW'(1);
          if (seg_q == '0) begin
            sw_d     = ~sw_q;
            seg_d    = seg_load;
            lfsr_adv = 1'b1;
          end else begin
            seg_d = seg_q - SegW'(1);
          end
        end else begin
          // Window over: settle at the latched level even if unchanged.
          sw_d    = target_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      bcnt_q   <= '0;
      seg_q    <= '0;
      sw_q     <= 1'b0;
      target_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      seg_q    <= seg_d;
      sw_q     <= sw_d;
      target_q <= target_d;
      done_q   <= done_d;
    end
  end

  assign sw_o   = sw_q;
  assign busy_o = (state_q == BOUNCE);
  assign done_o = done_q;

endmodule

// File: tb/tb_switch_bounce_gen.sv
// Scoreboard bench for switch_bounce_gen: a waveform-level model pushes the
// expected outputs per cycle, a monitor pops and compares them.
module tb_switch_bounce_gen;

  localparam int          WIN      = 100;  // 1 MHz * 100 us
  localparam int          MIN_SEG  = 2;
  localparam int          RAND_MAX = 7;    // 2^3 - 1

  typedef struct packed {
    logic sw;
    logic busy;
    logic done;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  switch_bounce_gen_if bus ();
  switch_bounce_gen_if bus_z ();

  assign bus_z.start  = bus.start;
  assign bus_z.target = bus.target;

  switch_bounce_gen #(
    .ClkFreq(1_000_000), .BounceTimeUs(100), .MinSegCycles(2), .SegBits(3),
    .LfsrSeed(16'hACE1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(bus.start), .target_i(bus.target),
    .sw_o(bus.sw), .busy_o(bus.busy), .done_o(bus.done)
  );

  switch_bounce_gen #(
    .ClkFreq(1_000_000), .BounceTimeUs(100), .MinSegCycles(2), .SegBits(3),
    .LfsrSeed(16'h0000)
  ) dut_z (
    .clk_i(clk), .rst_i(rst), .start_i(bus_z.start), .target_i(bus_z.target),
    .sw_o(bus_z.sw), .busy_o(bus_z.busy), .done_o(bus_z.done)
  );

  always #5 clk = ~clk;

  int vectors   = 0;
  int miscompares = 0;
  int cycle     = 0;

  obs_t exp_q[$];
  obs_t trace_q[$];
  logic [15:0] m_lfsr = 16'hACE1;
  logic        m_sw   = 1'b0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // Build the whole expected waveform of one accepted sequence.
  task automatic gen_sequence(input logic tgt);
    int   pos = 0;
    int   len;
    logic lvl = ~m_sw;
    while (pos < WIN) begin
      len    = MIN_SEG + int'(m_lfsr & 16'h0007);
      m_lfsr = lfsr_next(m_lfsr);
      for (int i = 0; i < len && pos < WIN; i++) begin
        trace_q.push_back('{sw: lvl, busy: 1'b1, done: 1'b0});
        pos++;
      end
      lvl = ~lvl;
    end
    trace_q.push_back('{sw: tgt, busy: 1'b0, done: 1'b1});
    m_sw = tgt;
  endtask

  // Model reaction to one clock edge with the given inputs.
  task automatic model_edge(input logic r, input logic s, input logic t);
    obs_t e;
    if (r) begin
      trace_q.delete();
      m_sw   = 1'b0;
      m_lfsr = 16'hACE1;
      e      = '{sw: 1'b0, busy: 1'b0, done: 1'b0};
    end else begin
      if (trace_q.size() == 0 && s) gen_sequence(t);
      if (trace_q.size() != 0) e = trace_q.pop_front();
      else                     e = '{sw: m_sw, busy: 1'b0, done: 1'b0};
    end
    exp_q.push_back(e);
  endtask

  task automatic step(input logic r, input logic s, input logic t);
    @(negedge clk);
    rst        = r;
    bus.start  = s;
    bus.target = t;
    @(posedge clk);
    model_edge(r, s, t);
  endtask

  task automatic check(input string name, input obs_t got, input obs_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cycle=%0d got sw=%b busy=%b done=%b need sw=%b busy=%b done=%b",
               name, cycle, got.sw, got.busy, got.done, exp.sw, exp.busy, exp.done);
    end else begin
      $display("ok   %s cycle=%0d sw=%b busy=%b done=%b", name, cycle,
               got.sw, got.busy, got.done);
    end
  endtask

  // Monitor: compare both instances against the model every cycle and
  // independently check that internal stable intervals stay in range.
  logic prev_sw   = 1'b0;
  logic prev_busy = 1'b0;
  int   run_len   = 0;
  initial begin
    obs_t e;
    obs_t g;
    forever begin
      @(negedge clk);
      cycle++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        g = '{sw: bus.sw, busy: bus.busy, done: bus.done};
        check("seed_ace1", g, e);
        g = '{sw: bus_z.sw, busy: bus_z.busy, done: bus_z.done};
        check("seed_zero", g, e);
        if (bus.busy && prev_busy) begin
          if (bus.sw != prev_sw) begin
            vectors++;
            if (run_len < MIN_SEG || run_len > MIN_SEG + RAND_MAX) begin
              miscompares++;
              $display("FAIL interval cycle=%0d got len=%0d need %0d..%0d",
                       cycle, run_len, MIN_SEG, MIN_SEG + RAND_MAX);
            end
            run_len = 1;
          end else begin
            run_len++;
          end
        end else if (bus.busy) begin
          run_len = 1;
        end
        prev_sw   = bus.sw;
        prev_busy = bus.busy;
      end
    end
  end

  logic rnd_start  [400];
  logic rnd_target [400];

  // Stimulus: directed scenarios followed by a replayed random phase.
  initial begin
    bus.start  = 1'b0;
    bus.target = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rnd_start[i]  = ($urandom_range(0, 15) == 0);
      rnd_target[i] = 1'($urandom_range(0, 1));
    end

    // Reset for 3 cycles with a start pulse inside it.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);

    // Single sequence to level 1.
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 110; i++) step(1'b0, 1'b0, 1'b0);

    // start held high for 300 cycles, target 0.
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);

    // Reset at T+40 of a sequence, then a fresh sequence.
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 39; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 110; i++) step(1'b0, 1'b0, 1'b0);

    // Same random stimulus twice, each from reset.
    for (int pass = 0; pass < 2; pass++) begin
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 400; i++) step(1'b0, rnd_start[i], rnd_target[i]);
    end

    step(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain got %0d pending need 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
